// File: rtl/rle_sched_pkg.sv
// Shared types for the rle job scheduler: FSM states, completion status codes,
// the host descriptor layout and the size screen applied before launch.
// Pure declarations; no clocked logic lives here.
package rle_sched_pkg;

    // Scheduler FSM encoding.
    typedef enum logic [1:0] {
        SCH_IDLE   = 2'd0,
        SCH_LAUNCH = 2'd1,
        SCH_WAIT   = 2'd2,
        SCH_REPORT = 2'd3
    } sched_state_e;

    // Completion status reported back to the host.
    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_ZERO     = 2'd1,
        ST_OVERSIZE = 2'd2,
        ST_TIMEOUT  = 2'd3
    } cmp_status_e;

    // Host frame descriptor, 100 bits.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] size;
        logic [31:0] rle_addr;
        logic [3:0]  tag;
    } desc_t;

    localparam int DESC_W = $bits(desc_t);

    // Decide whether a job may be launched. ST_OK means "launch it"; any
    // other code is the final status of a job that never reaches the engine.
    function automatic cmp_status_e screen_size(input logic [31:0] size,
                                                input logic [31:0] max_size);
        cmp_status_e res;
        res = ST_OK;
        if (size == 32'd0) begin
            res = ST_ZERO;
        end else if (size > max_size) begin
            res = ST_OVERSIZE;
        end
        return res;
    endfunction

endpackage

// File: rtl/rle_desc_fifo.sv
// Descriptor queue: DEPTH-entry FIFO of WIDTH-bit words, head word shown on pop_data.
// Latency: a word pushed at edge T is visible at the head from cycle T+1.
// Backpressure: a push while full is dropped (caller gates on !full); pop while empty is ignored.
module rle_desc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 100
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count    = wr_ptr - rd_ptr;
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Advance the wrapping pointers on accepted push/pop.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/rle_job_scheduler.sv
// Queues host descriptors and runs them one at a time on the rle engine via start/done.
// Latency: push at edge T -> rle_start in cycle T+2; done in cycle D -> cmp_valid in D+1.
// Backpressure: job_ready low while queue full or engine hung; completion held until cmp_ready.
module rle_job_scheduler
    import rle_sched_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int MAX_MSG_SIZE   = 255,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     job_valid,
    output logic                     job_ready,
    input  logic [31:0]              job_msg_addr,
    input  logic [31:0]              job_msg_size,
    input  logic [31:0]              job_rle_addr,
    input  logic [3:0]               job_tag,
    output logic                     rle_start,
    output logic [31:0]              rle_message_addr,
    output logic [31:0]              rle_message_size,
    output logic [31:0]              rle_rle_addr,
    input  logic                     rle_done,
    input  logic [31:0]              rle_size,
    output logic                     cmp_valid,
    input  logic                     cmp_ready,
    output logic [3:0]               cmp_tag,
    output logic [1:0]               cmp_status,
    output logic [31:0]              cmp_rle_size,
    output logic                     busy,
    output logic                     engine_hung,
    output logic [$clog2(DEPTH):0]   queue_count
);

    localparam logic [1:0]  S_IDLE   = SCH_IDLE;
    localparam logic [1:0]  S_LAUNCH = SCH_LAUNCH;
    localparam logic [1:0]  S_WAIT   = SCH_WAIT;
    localparam logic [1:0]  S_REPORT = SCH_REPORT;

    localparam int          WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] MAX_SIZE = 32'(MAX_MSG_SIZE);

    logic [1:0]         state;
    desc_t              job_q;
    logic [WD_W-1:0]    wd_cnt;
    logic               hung_q;
    logic               turnaround;
    logic [1:0]         cmp_status_q;
    logic [31:0]        cmp_size_q;

    desc_t              in_desc;
    desc_t              head;
    logic [DESC_W-1:0]  head_dat;
    cmp_status_e        head_screen;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push_ok;
    logic               pop_ok;

    assign in_desc.addr     = job_msg_addr;
    assign in_desc.size     = job_msg_size;
    assign in_desc.rle_addr = job_rle_addr;
    assign in_desc.tag      = job_tag;

    assign job_ready   = ~fifo_full & ~hung_q;
    assign push_ok     = job_valid & job_ready;

    // A hung engine freezes the queue; the single turnaround cycle after
    // each completion keeps done-to-next-start at a fixed four cycles.
    assign pop_ok      = (state == S_IDLE) & ~fifo_empty & ~hung_q & ~turnaround;

    assign head        = desc_t'(head_dat);
    assign head_screen = screen_size(head.size, MAX_SIZE);

    rle_desc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DESC_W)
    ) u_fifo (
        .clk       (clk),
        .nreset    (nreset),
        .push      (push_ok),
        .push_data (in_desc),
        .pop       (pop_ok),
        .pop_data  (head_dat),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (queue_count)
    );

    // Job FSM: pop and screen in IDLE, pulse start, wait for done, hold the record.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state        <= S_IDLE;
            job_q        <= '0;
            turnaround   <= 1'b0;
            cmp_status_q <= '0;
            cmp_size_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    turnaround <= 1'b0;
                    if (pop_ok) begin
                        job_q      <= head;
                        cmp_size_q <= '0;
                        if (head_screen == ST_OK) begin
                            state <= S_LAUNCH;
                        end else begin
                            cmp_status_q <= head_screen;
                            state        <= S_REPORT;
                        end
                    end
                end
                S_LAUNCH: begin
                    // done is still high from the previous job here, so it is not looked at.
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (rle_done) begin
                        cmp_status_q <= ST_OK;
                        cmp_size_q   <= rle_size;
                        state        <= S_REPORT;
                    end else if (wd_cnt == WD_LIMIT) begin
                        cmp_status_q <= ST_TIMEOUT;
                        cmp_size_q   <= '0;
                        state        <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    if (cmp_ready) begin
                        cmp_status_q <= '0;
                        cmp_size_q   <= '0;
                        turnaround   <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Watchdog: cleared as the job launches, counts every cycle spent waiting.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wd_cnt <= '0;
        end else if (state == S_LAUNCH) begin
            wd_cnt <= '0;
        end else if (state == S_WAIT) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Sticky hung flag: set on a watchdog expiry without done, cleared only by reset.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            hung_q <= 1'b0;
        end else if ((state == S_WAIT) && !rle_done && (wd_cnt == WD_LIMIT)) begin
            hung_q <= 1'b1;
        end
    end

    assign rle_start        = (state == S_LAUNCH);
    assign rle_message_addr = job_q.addr;
    assign rle_message_size = job_q.size;
    assign rle_rle_addr     = job_q.rle_addr;

    assign cmp_valid        = (state == S_REPORT);
    assign cmp_tag          = cmp_valid ? job_q.tag : 4'd0;
    assign cmp_status       = cmp_status_q;
    assign cmp_rle_size     = cmp_size_q;

    assign busy             = (state != S_IDLE) | ~fifo_empty;
    assign engine_hung      = hung_q;

endmodule

// File: tb/tb_rle_job_scheduler.sv
// Scoreboarded bench for rle_job_scheduler: main instance with an engine model,
// plus a short-watchdog instance whose engine never answers.
module tb_rle_job_scheduler;
    import rle_sched_pkg::*;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- main instance ----------------
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [31:0] job_msg_addr = '0, job_msg_size = '0, job_rle_addr = '0;
    logic [3:0]  job_tag = '0;
    logic        rle_start;
    logic [31:0] rle_message_addr, rle_message_size, rle_rle_addr;
    logic        rle_done;
    logic [31:0] rle_size;
    logic        cmp_valid;
    logic        cmp_ready = 1'b1;
    logic [3:0]  cmp_tag;
    logic [1:0]  cmp_status;
    logic [31:0] cmp_rle_size;
    logic        busy, engine_hung;
    logic [2:0]  queue_count;

    rle_job_scheduler #(.DEPTH(4), .MAX_MSG_SIZE(255), .TIMEOUT_CYCLES(4096)) dut (
        .clk(clk), .nreset(nreset),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_msg_addr(job_msg_addr), .job_msg_size(job_msg_size),
        .job_rle_addr(job_rle_addr), .job_tag(job_tag),
        .rle_start(rle_start), .rle_message_addr(rle_message_addr),
        .rle_message_size(rle_message_size), .rle_rle_addr(rle_rle_addr),
        .rle_done(rle_done), .rle_size(rle_size),
        .cmp_valid(cmp_valid), .cmp_ready(cmp_ready), .cmp_tag(cmp_tag),
        .cmp_status(cmp_status), .cmp_rle_size(cmp_rle_size),
        .busy(busy), .engine_hung(engine_hung), .queue_count(queue_count)
    );

    // ---------------- watchdog instance (engine never done) ----------------
    logic        t_job_valid = 1'b0;
    logic        t_job_ready;
    logic [31:0] t_job_msg_addr = 32'h40, t_job_msg_size = 32'd16, t_job_rle_addr = 32'h200;
    logic [3:0]  t_job_tag = 4'd5;
    logic        t_rle_start;
    logic [31:0] t_rle_message_addr, t_rle_message_size, t_rle_rle_addr;
    logic        t_rle_done = 1'b0;
    logic [31:0] t_rle_size = '0;
    logic        t_cmp_valid;
    logic        t_cmp_ready = 1'b1;
    logic [3:0]  t_cmp_tag;
    logic [1:0]  t_cmp_status;
    logic [31:0] t_cmp_rle_size;
    logic        t_busy, t_engine_hung;
    logic [2:0]  t_queue_count;

    rle_job_scheduler #(.DEPTH(4), .MAX_MSG_SIZE(255), .TIMEOUT_CYCLES(16)) dut_to (
        .clk(clk), .nreset(nreset),
        .job_valid(t_job_valid), .job_ready(t_job_ready),
        .job_msg_addr(t_job_msg_addr), .job_msg_size(t_job_msg_size),
        .job_rle_addr(t_job_rle_addr), .job_tag(t_job_tag),
        .rle_start(t_rle_start), .rle_message_addr(t_rle_message_addr),
        .rle_message_size(t_rle_message_size), .rle_rle_addr(t_rle_rle_addr),
        .rle_done(t_rle_done), .rle_size(t_rle_size),
        .cmp_valid(t_cmp_valid), .cmp_ready(t_cmp_ready), .cmp_tag(t_cmp_tag),
        .cmp_status(t_cmp_status), .cmp_rle_size(t_cmp_rle_size),
        .busy(t_busy), .engine_hung(t_engine_hung), .queue_count(t_queue_count)
    );

    // Engine model: done level drops on start, rises eng_delay cycles after start
    // with rle_size = message_size / 2; eng_stall freezes it.
    logic eng_stall = 1'b0;
    int   eng_delay = 20;
    int   eng_cnt;
    logic eng_run;
    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rle_done <= 1'b0; rle_size <= '0; eng_cnt <= 0; eng_run <= 1'b0;
        end else if (rle_start) begin
            rle_done <= 1'b0; eng_run <= 1'b1; eng_cnt <= 1;
        end else if (eng_run && !eng_stall) begin
            if (eng_cnt >= eng_delay - 1) begin
                rle_done <= 1'b1; rle_size <= rle_message_size >> 1; eng_run <= 1'b0;
            end else begin
                eng_cnt <= eng_cnt + 1;
            end
        end
    end

    int start_count = 0;
    always @(negedge clk) if (rle_start) start_count <= start_count + 1;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [3:0]  tag;
        logic [1:0]  status;
        logic [31:0] size;
    } exp_t;
    exp_t sb_q[$];

    task automatic expect_cmp(input logic [3:0] t, input logic [1:0] s, input logic [31:0] z);
        exp_t e;
        e.tag = t; e.status = s; e.size = z;
        sb_q.push_back(e);
    endtask

    // Monitor: every cycle a record is presented it must equal the queue head,
    // so a record that changes while held back also shows up.
    always @(negedge clk) begin
        if (nreset && cmp_valid) begin
            if (sb_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL cmp_unexpected: got tag %0d status %0d size %0d, expected no completion",
                         cmp_tag, cmp_status, cmp_rle_size);
            end else begin
                check("cmp_tag", 32'(cmp_tag), 32'(sb_q[0].tag));
                check("cmp_status", 32'(cmp_status), 32'(sb_q[0].status));
                check("cmp_rle_size", cmp_rle_size, sb_q[0].size);
                if (cmp_ready) void'(sb_q.pop_front());
            end
        end
    end

    // Bounded wait on an event; 0 start, 1 cmp_valid, 2 t_rle_start, 3 t_cmp_valid, 4 scoreboard drained.
    task automatic wait_evt(input int which, input int limit, input string name, output int c);
        bit hit;
        hit = 1'b0;
        c = -1;
        for (int n = 0; n < limit && !hit; n++) begin
            @(negedge clk);
            case (which)
                0:       hit = rle_start;
                1:       hit = cmp_valid;
                2:       hit = t_rle_start;
                3:       hit = t_cmp_valid;
                default: hit = (sb_q.size() == 0);
            endcase
            if (hit) c = cyc;
        end
        if (!hit) begin
            n_checks++; n_fail++;
            $display("FAIL %s: got no event in %0d cycles, expected one", name, limit);
        end
    endtask

    // Called at a negedge; returns the cycle where the push was accepted and the count seen then.
    task automatic push_job(input logic [31:0] a, input logic [31:0] s, input logic [31:0] r,
                            input logic [3:0] t, output int c, output int qc);
        int n;
        job_msg_addr = a; job_msg_size = s; job_rle_addr = r; job_tag = t;
        job_valid = 1'b1;
        n = 0;
        while (!job_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        c = cyc;
        qc = int'(queue_count);
        if (!job_ready) begin
            n_checks++; n_fail++;
            $display("FAIL push_tag%0d: got job_ready 0 for 200 cycles, expected acceptance", t);
        end
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no end of test, expected one");
        $fatal(1);
    end

    initial begin
        int c, qc, s, v, r, sc;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_job_ready", 32'(job_ready), 1);
        check("rst_rle_start", 32'(rle_start), 0);
        check("rst_cmp_valid", 32'(cmp_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_hung", 32'(engine_hung), 0);
        check("rst_qcount", 32'(queue_count), 0);
        check("rst_msg_size", rle_message_size, 0);
        nreset = 1'b1;
        @(negedge clk);

        // Single job, done 20 cycles after start
        eng_delay = 20;
        expect_cmp(4'd3, ST_OK, 32'd4);
        push_job(32'h0, 32'd8, 32'h100, 4'd3, c, qc);
        wait_evt(0, 20, "t1_start", s);
        check("t1_start_cycle", s, c + 2);
        @(negedge clk);
        check("t1_start_width", 32'(rle_start), 0);
        check("t1_msg_size", rle_message_size, 32'd8);
        check("t1_rle_addr", rle_rle_addr, 32'h100);
        check("t1_busy", 32'(busy), 1);
        wait_evt(1, 100, "t1_cmp", v);
        check("t1_cmp_cycle", v, s + 21);
        wait_evt(4, 50, "t1_drain", v);
        @(negedge clk);
        check("t1_idle_busy", 32'(busy), 0);

        // Five jobs against a stalled engine, queue depth 4
        eng_stall = 1'b1;
        eng_delay = 3;
        expect_cmp(4'd0, ST_OK, 32'd5);
        push_job(32'h1000, 32'd10, 32'h2000, 4'd0, c, qc);
        wait_evt(0, 20, "t2_start0", s);
        expect_cmp(4'd1, ST_OK, 32'd10);
        push_job(32'h1100, 32'd20, 32'h2100, 4'd1, c, qc);
        expect_cmp(4'd2, ST_OK, 32'd15);
        push_job(32'h1200, 32'd30, 32'h2200, 4'd2, c, qc);
        expect_cmp(4'd3, ST_OK, 32'd20);
        push_job(32'h1300, 32'd40, 32'h2300, 4'd3, c, qc);
        expect_cmp(4'd4, ST_OK, 32'd25);
        push_job(32'h1400, 32'd50, 32'h2400, 4'd4, c, qc);
        check("t2_full_count", 32'(queue_count), 4);
        check("t2_full_ready", 32'(job_ready), 0);
        job_msg_addr = 32'h1500; job_msg_size = 32'd60; job_rle_addr = 32'h2500; job_tag = 4'd5;
        job_valid = 1'b1;
        repeat (5) @(negedge clk);
        check("t2_held_ready", 32'(job_ready), 0);
        check("t2_held_count", 32'(queue_count), 4);
        expect_cmp(4'd5, ST_OK, 32'd30);
        eng_stall = 1'b0;
        push_job(32'h1500, 32'd60, 32'h2500, 4'd5, c, qc);
        check("t2_fifth_after_pop", qc, 3);
        wait_evt(4, 400, "t2_drain", v);

        // Screened sizes: zero, oversize, and the 255/256 boundary
        sc = start_count;
        expect_cmp(4'd6, ST_ZERO, 32'd0);
        push_job(32'h3000, 32'd0, 32'h3100, 4'd6, c, qc);
        wait_evt(1, 20, "t3_zero_cmp", v);
        check("t3_zero_cycle", v, c + 2);
        wait_evt(4, 20, "t3_drain0", v);
        expect_cmp(4'd7, ST_OVERSIZE, 32'd0);
        push_job(32'h3200, 32'd300, 32'h3300, 4'd7, c, qc);
        wait_evt(1, 20, "t3_over_cmp", v);
        check("t3_over_cycle", v, c + 2);
        wait_evt(4, 20, "t3_drain1", v);
        check("t3_no_start", start_count, sc);
        expect_cmp(4'd1, ST_OK, 32'd127);
        push_job(32'h3400, 32'd255, 32'h3500, 4'd1, c, qc);
        expect_cmp(4'd2, ST_OVERSIZE, 32'd0);
        push_job(32'h3600, 32'd256, 32'h3700, 4'd2, c, qc);
        wait_evt(4, 100, "t3_drain2", v);
        check("t3_one_start", start_count, sc + 1);

        // Completion held back for 10 cycles with a job queued behind it
        cmp_ready = 1'b0;
        expect_cmp(4'd8, ST_OK, 32'd6);
        push_job(32'h4000, 32'd12, 32'h4100, 4'd8, c, qc);
        expect_cmp(4'd9, ST_OK, 32'd7);
        push_job(32'h4200, 32'd14, 32'h4300, 4'd9, c, qc);
        wait_evt(1, 50, "t4_cmp", v);
        sc = start_count;
        repeat (10) @(negedge clk);
        check("t4_valid_held", 32'(cmp_valid), 1);
        check("t4_queued", 32'(queue_count), 1);
        check("t4_no_start", start_count, sc);
        @(posedge clk);
        #1 cmp_ready = 1'b1;
        r = cyc;
        wait_evt(0, 20, "t4_next_start", s);
        check("t4_start_cycle", s, r + 3);
        wait_evt(4, 100, "t4_drain", v);

        // Watchdog instance: engine never answers, TIMEOUT_CYCLES = 16
        @(negedge clk);
        t_job_valid = 1'b1;
        c = cyc;
        check("t5_ready", 32'(t_job_ready), 1);
        @(negedge clk);
        t_job_valid = 1'b0;
        wait_evt(2, 20, "t5_start", s);
        check("t5_start_cycle", s, c + 2);
        wait_evt(3, 100, "t5_cmp", v);
        check("t5_cmp_cycle", v, s + 17);
        check("t5_tag", 32'(t_cmp_tag), 5);
        check("t5_status", 32'(t_cmp_status), 32'(ST_TIMEOUT));
        check("t5_size", t_cmp_rle_size, 0);
        @(negedge clk);
        check("t5_hung", 32'(t_engine_hung), 1);
        check("t5_cmp_cleared", 32'(t_cmp_valid), 0);
        t_job_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_hung_ready", 32'(t_job_ready), 0);
        check("t5_hung_count", 32'(t_queue_count), 0);
        check("t5_hung_still", 32'(t_engine_hung), 1);
        t_job_valid = 1'b0;

        // Reset during WAIT with two jobs queued
        eng_stall = 1'b1;
        push_job(32'h5000, 32'd16, 32'h5100, 4'd10, c, qc);
        wait_evt(0, 20, "t6_start", s);
        push_job(32'h5200, 32'd18, 32'h5300, 4'd11, c, qc);
        push_job(32'h5400, 32'd20, 32'h5500, 4'd12, c, qc);
        check("t6_queued", 32'(queue_count), 2);
        #2 nreset = 1'b0;
        #1;
        sb_q.delete();
        check("t6_job_ready", 32'(job_ready), 1);
        check("t6_qcount", 32'(queue_count), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_rle_start", 32'(rle_start), 0);
        check("t6_cmp_valid", 32'(cmp_valid), 0);
        check("t6_msg_addr", rle_message_addr, 0);
        check("t6_msg_size", rle_message_size, 0);
        check("t6_rle_addr", rle_rle_addr, 0);
        check("t6_t_hung", 32'(t_engine_hung), 0);
        check("t6_t_ready", 32'(t_job_ready), 1);
        @(negedge clk);
        nreset = 1'b1;
        eng_stall = 1'b0;
        @(negedge clk);

        // Recovery after reset
        expect_cmp(4'd13, ST_OK, 32'd2);
        push_job(32'h6000, 32'd4, 32'h6100, 4'd13, c, qc);
        wait_evt(0, 20, "t7_start", s);
        check("t7_start_cycle", s, c + 2);
        wait_evt(4, 50, "t7_drain", v);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
